// File: rtl/tomasulo_pkg.sv
// Shared types and widths for the Tomasulo common-data-bus logic.
package tomasulo_pkg;

  localparam int unsigned TAG_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {IDLE, BEAT2} cdb_state_t;

  typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: returns the first asserted request at or after ptr,
// wrapping modulo N.
module rr_priority_pick #(
  parameter int unsigned N = 6,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  logic [31:0] j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = 0; k < int'(N); k++) begin
      j = (32'(ptr) + 32'(k)) % 32'(N);
      if (!found && req[j[PW-1:0]]) begin
        found = 1'b1;
        idx   = j[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Round-robin common-data-bus arbiter with registered broadcast and optional
// two-beat (lo then hi word) transfers for wide producers.
module cdb_rr_arbiter #(
  parameter int unsigned         N_REQ       = 6,
  parameter int unsigned         TAG_W       = tomasulo_pkg::TAG_W,
  parameter int unsigned         DATA_W      = tomasulo_pkg::DATA_W,
  parameter logic [N_REQ-1:0]    DOUBLE_MASK = 6'b011000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_data_lo,
  input  logic [N_REQ*DATA_W-1:0]   req_data_hi,
  output logic [N_REQ-1:0]          ack,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic                      cdb_hi,
  output logic                      busy
);

  import tomasulo_pkg::*;

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  cdb_state_t        state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              hi_q, hi_d;
  logic [N_REQ-1:0]  ack_c;
  logic              found;
  logic [PW-1:0]     win;

  rr_priority_pick #(
    .N(N_REQ)
  ) u_pick (
    .req  (req),
    .ptr  (rr_ptr_q),
    .found(found),
    .idx  (win)
  );

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] i);
    return (i == PW'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    valid_d  = 1'b0;
    tag_d    = tag_q;
    data_d   = data_q;
    hi_d     = 1'b0;
    ack_c    = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          valid_d = 1'b1;
          tag_d   = req_tag[win*TAG_W +: TAG_W];
          data_d  = req_data_lo[win*DATA_W +: DATA_W];
          // Double-beat winners are only acked on their final (hi) beat.
          if (DOUBLE_MASK[win]) begin
            sel_d   = win;
            state_d = BEAT2;
          end else begin
            ack_c[win] = 1'b1;
            rr_ptr_d   = ptr_after(win);
          end
        end
      end
      BEAT2: begin
        ack_c[sel_q] = 1'b1;
        valid_d      = 1'b1;
        hi_d         = 1'b1;
        tag_d        = req_tag[sel_q*TAG_W +: TAG_W];
        data_d       = req_data_hi[sel_q*DATA_W +: DATA_W];
        rr_ptr_d     = ptr_after(sel_q);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      tag_q    <= '0;
      data_q   <= '0;
      hi_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      hi_q     <= hi_d;
    end
  end

  // ack is combinational, so it must be masked explicitly while reset is held.
  assign ack       = ack_c & {N_REQ{reset}};
  assign busy      = (state_q == BEAT2);
  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;
  assign cdb_hi    = hi_q;

endmodule
